fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard controller for the pipelined core.
- Generalises the two-operand, two-stage forwarding selects to NUM_SRC operands and FWD_DEPTH producer stages, each with priority encoding.
- Adds a load-use stall FSM with a programmable stall length, a pipeline flush override and a saturating stall counter.
- Sits beside the ID/EX pipeline registers and drives the EX operand muxes, the PC/IF-ID hold and the ID/EX bubble insert.

Parameters:
- REG_ADDR_W, 3: register specifier width.
- NUM_SRC, 2: consumer operand channels (0 = Rs, 1 = Rt).
- FWD_DEPTH, 2: producer stages (stage 0 = EX/MEM, the youngest; stage 1 = MEM/WB).
- LOAD_LAT, 1: stall cycles per load-use hazard, range 1..15.
- Derived localparam SEL_W = $clog2(FWD_DEPTH+1).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ex_src  in  NUM_SRC*REG_ADDR_W  EX-stage consumer source specifiers; channel j occupies bits [j*REG_ADDR_W +: REG_ADDR_W].
- ex_use  in  NUM_SRC  EX consumer actually reads channel j.
- prod_rd  in  FWD_DEPTH*REG_ADDR_W  destination specifier of producer stage k.
- prod_wr  in  FWD_DEPTH  producer stage k writes the register file.
- id_src  in  NUM_SRC*REG_ADDR_W  ID-stage source specifiers.
- id_use  in  NUM_SRC  ID instruction reads channel j.
- ex_rd  in  REG_ADDR_W  destination of the instruction currently in EX.
- ex_wr  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a load.
- flush  in  1  branch/jump flush, synchronous.
- fwd_sel  out  NUM_SRC*SEL_W  per channel: 0 = register file, k+1 = producer stage k.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero the ID/EX control bits.
- stall_cnt  out  16  total stall cycles, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE, the down-counter to 0, stall_cnt to 0.
  - fwd_sel, stall and bubble are forced to 0 combinationally while rst=0.
- Forwarding (combinational):
  - Channel j matches stage k when ex_use[j] & prod_wr[k] & (ex_src_j == prod_rd_k).
  - The lowest matching k wins; fwd_sel_j = k+1.
  - No match gives 0.
  - Comparisons are 2-state; X/Z on a specifier is treated as no match.
- Hazard detect: hz = OR over j of (id_use[j] & ex_wr & ex_is_load & id_src_j == ex_rd).
- FSM, states IDLE and STALL:
  - IDLE:
    - hz & !flush sets stall=1 and bubble=1 in the same cycle (Mealy output).
    - If LOAD_LAT>1: go to STALL, load the counter with LOAD_LAT-1.
    - If LOAD_LAT=1: remain in IDLE.
  - STALL:
    - stall=1 and bubble=1.
    - The counter decrements each cycle.
    - Counter==1 moves the FSM to IDLE on the next edge.
    - hz is ignored while in STALL.
  - flush has priority in both states:
    - stall=0 and bubble=0 that cycle.
    - Next state is IDLE and the counter clears.
- stall_cnt: +1 on every clock edge where stall=1; it saturates at 16'hFFFF.
- A flush arriving mid-stall truncates the stall. Cycles already stalled remain counted.
- Back-to-back loads: a second hazard detected in IDLE, immediately after release, restarts the stall.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined: specifier 0 is hardwired zero.
  - A producer with prod_rd_k==0 never forwards.
  - ex_rd==0 never raises hz.
- Undefined: register 0 is an ordinary register and matches like any other.

Test Plan:
- Forwarding priority, defaults:
  - ex_src0=3, ex_use=2'b01, prod_rd={3,3}, prod_wr=2'b11 -> fwd_sel0=1 (stage 0 wins).
  - Deassert prod_wr[0] -> fwd_sel0=2.
  - ex_use=0 -> fwd_sel0=0.
- Load-use, LOAD_LAT=1: ex_is_load=1, ex_wr=1, ex_rd=5, id_src1=5, id_use=2'b10 -> stall=bubble=1 for exactly 1 cycle, stall_cnt=1.
- Load-use, LOAD_LAT=3, same stimulus held for one cycle then ex_wr=0 -> stall high for 3 consecutive cycles, stall_cnt=3, then 0.
- Flush mid-stall, LOAD_LAT=3: assert flush in the 2nd stall cycle -> stall=0 that cycle, FSM in IDLE, stall_cnt=1.
- Async reset: drop rst mid-stall between clock edges -> stall, bubble, fwd_sel and stall_cnt are 0 immediately; after rst release with no hazard, outputs stay 0.
- ZERO_REG_EN: prod_rd0=0, prod_wr[0]=1, ex_src0=0, ex_use[0]=1 -> fwd_sel0=0 with the macro defined, 1 without.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-operand forwarding selects plus a load-use stall FSM.
// Each consumer operand channel gets its own lane instance, which does both
//   - the forwarding priority encode
//   - the ID-side load-use compare
// Optional build macro: ZERO_REG_EN. When defined, specifier 0 is hardwired
// zero: it never forwards and never raises a load-use hazard.

// Per-channel lane: forwarding priority encode and the ID-side hazard compare.
module fwd_hazard_lane #(
   parameter int REG_ADDR_W = 3,
   parameter int FWD_DEPTH  = 2,
   parameter int SEL_W      = 2
) (
   input  logic [REG_ADDR_W-1:0]           ex_src,
   input  logic                            ex_use,
   input  logic [FWD_DEPTH*REG_ADDR_W-1:0] prod_rd,
   input  logic [FWD_DEPTH-1:0]            prod_wr,
   input  logic [REG_ADDR_W-1:0]           id_src,
   input  logic                            id_use,
   input  logic [REG_ADDR_W-1:0]           ex_rd,
   input  logic                            ex_ld_wr,
   output logic [SEL_W-1:0]                sel,
   output logic                            hz
);

   // Scan oldest to youngest so the lowest matching stage is the last write.
   // Comparisons sit in if-conditions, so an X/Z specifier reads as no match.
   always_comb begin
      sel = '0;
      for (int k = FWD_DEPTH-1; k >= 0; k--) begin
         if (ex_use && prod_wr[k] &&
             (ex_src == prod_rd[k*REG_ADDR_W +: REG_ADDR_W])
`ifdef ZERO_REG_EN
             && (prod_rd[k*REG_ADDR_W +: REG_ADDR_W] != '0)
`endif
            )
            sel = SEL_W'(k+1);
      end
   end

   // Load-use compare against the instruction now in EX.
   always_comb begin
      hz = 1'b0;
      if (id_use && ex_ld_wr && (id_src == ex_rd))
         hz = 1'b1;
   end

endmodule

module fwd_hazard_unit #(
   parameter int REG_ADDR_W = 3,
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = 2,
   parameter int LOAD_LAT   = 1,
   localparam int SEL_W     = $clog2(FWD_DEPTH+1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]   ex_src,
   input  logic [NUM_SRC-1:0]              ex_use,
   input  logic [FWD_DEPTH*REG_ADDR_W-1:0] prod_rd,
   input  logic [FWD_DEPTH-1:0]            prod_wr,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src,
   input  logic [NUM_SRC-1:0]              id_use,
   input  logic [REG_ADDR_W-1:0]           ex_rd,
   input  logic                            ex_wr,
   input  logic                            ex_is_load,
   input  logic                            flush,
   output logic [NUM_SRC*SEL_W-1:0]        fwd_sel,
   output logic                            stall,
   output logic                            bubble,
   output logic [15:0]                     stall_cnt
);

   typedef enum logic {IDLE, STALL} state_t;

   state_t                           state, state_nxt;
   logic   [3:0]                     cnt, cnt_nxt;
   logic   [NUM_SRC-1:0][SEL_W-1:0]  sel_raw;
   logic   [NUM_SRC-1:0]             hz_vec;
   logic                             hz, rd_ok, stall_raw;

`ifdef ZERO_REG_EN
   assign rd_ok = (ex_rd != '0);
`else
   assign rd_ok = 1'b1;
`endif

   genvar j;
   generate
      for (j = 0; j < NUM_SRC; j++) begin : g_lane
         fwd_hazard_lane #(
            .REG_ADDR_W(REG_ADDR_W), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)
         ) u_lane (
            .ex_src   (ex_src[j*REG_ADDR_W +: REG_ADDR_W]),
            .ex_use   (ex_use[j]),
            .prod_rd  (prod_rd),
            .prod_wr  (prod_wr),
            .id_src   (id_src[j*REG_ADDR_W +: REG_ADDR_W]),
            .id_use   (id_use[j]),
            .ex_rd    (ex_rd),
            .ex_ld_wr (ex_wr & ex_is_load),
            .sel      (sel_raw[j]),
            .hz       (hz_vec[j])
         );
      end
   endgenerate

   assign hz = (|hz_vec) & rd_ok;

   // Outputs are held low combinationally for the whole reset window.
   assign fwd_sel = rst ? sel_raw : '0;
   assign stall   = stall_raw & rst;
   assign bubble  = stall_raw & rst;

   // Next-state and Mealy stall; flush wins in either state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_raw = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (hz) begin
                  stall_raw = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_nxt = STALL;
                     cnt_nxt   = 4'(LOAD_LAT-1);
                  end
               end
            end
            STALL: begin
               stall_raw = 1'b1;
               cnt_nxt   = cnt - 4'd1;
               if (cnt == 4'd1)
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State and remaining-stall counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (stall_raw && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (LOAD_LAT=1 and LOAD_LAT=3) share inputs.
// Directed forwarding table, hand sequences for the stall corners, then random
// stimulus against a remaining-stall-cycles reference model.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] ex_src, id_src;
   logic [1:0] ex_use, id_use, prod_wr;
   logic [5:0] prod_rd;
   logic [2:0] ex_rd;
   logic       ex_wr, ex_is_load, flush;
   logic [3:0] fwd_sel1, fwd_sel3;
   logic       stall1, stall3, bubble1, bubble3;
   logic [15:0] cnt1, cnt3;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .ex_src(ex_src), .ex_use(ex_use), .prod_rd(prod_rd),
      .prod_wr(prod_wr), .id_src(id_src), .id_use(id_use), .ex_rd(ex_rd),
      .ex_wr(ex_wr), .ex_is_load(ex_is_load), .flush(flush),
      .fwd_sel(fwd_sel1), .stall(stall1), .bubble(bubble1), .stall_cnt(cnt1));

   fwd_hazard_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .ex_src(ex_src), .ex_use(ex_use), .prod_rd(prod_rd),
      .prod_wr(prod_wr), .id_src(id_src), .id_use(id_use), .ex_rd(ex_rd),
      .ex_wr(ex_wr), .ex_is_load(ex_is_load), .flush(flush),
      .fwd_sel(fwd_sel3), .stall(stall3), .bubble(bubble3), .stall_cnt(cnt3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clr_inputs();
      ex_src = '0; id_src = '0; ex_use = '0; id_use = '0; prod_wr = '0;
      prod_rd = '0; ex_rd = '0; ex_wr = 0; ex_is_load = 0; flush = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: first producer stage (youngest first) whose dest equals the source.
   function automatic logic [3:0] m_fwd(logic [5:0] src, logic [1:0] use_v,
                                        logic [5:0] rd, logic [1:0] wr);
      logic [3:0] r = '0;
      for (int ch = 0; ch < 2; ch++) begin
         int pick = 0;
         for (int k = 0; k < 2; k++) begin
            int s = (src >> (3*ch)) & 7;
            int d = (rd >> (3*k)) & 7;
            bit zero_blk = 0;
`ifdef ZERO_REG_EN
            zero_blk = (d == 0);
`endif
            if (pick == 0 && use_v[ch] && wr[k] && s == d && !zero_blk)
               pick = k + 1;
         end
         r = r | 4'(pick << (2*ch));
      end
      return r;
   endfunction

   function automatic bit m_hz(logic [5:0] src, logic [1:0] use_v, logic [2:0] rd,
                               logic wr, logic ld);
`ifdef ZERO_REG_EN
      if (rd == 0) return 0;
`endif
      if (!(wr && ld)) return 0;
      for (int ch = 0; ch < 2; ch++)
         if (use_v[ch] && (((src >> (3*ch)) & 7) == rd)) return 1;
      return 0;
   endfunction

   typedef struct {
      logic [5:0] src;
      logic [1:0] use_v;
      logic [5:0] rd;
      logic [1:0] wr;
      logic [3:0] exp;
   } fvec_t;

   fvec_t tbl[7];

   int rem1, rem3, mc1, mc3;

   initial begin
      // {ch1,ch0} source, use, {stage1,stage0} dest, write, expected {sel1,sel0}
      tbl[0] = '{ {3'd1,3'd3}, 2'b01, {3'd3,3'd3}, 2'b11, 4'b0001 };
      tbl[1] = '{ {3'd1,3'd3}, 2'b01, {3'd3,3'd3}, 2'b10, 4'b0010 };
      tbl[2] = '{ {3'd1,3'd3}, 2'b00, {3'd3,3'd3}, 2'b11, 4'b0000 };
      tbl[3] = '{ {3'd5,3'd3}, 2'b11, {3'd5,3'd3}, 2'b11, 4'b1001 };
      tbl[4] = '{ {3'd5,3'd3}, 2'b11, {3'd5,3'd3}, 2'b00, 4'b0000 };
      tbl[5] = '{ {3'd6,3'd6}, 2'b11, {3'd6,3'd6}, 2'b01, 4'b0101 };
      tbl[6] = '{ {3'd7,3'd2}, 2'b11, {3'd4,3'd1}, 2'b11, 4'b0000 };

      // Reset state
      clr_inputs();
      rst = 0;
      #12;
      chk("rst_stall1", 32'(stall1), 0);
      chk("rst_stall3", 32'(stall3), 0);
      chk("rst_bubble3", 32'(bubble3), 0);
      chk("rst_cnt3", 32'(cnt3), 0);
      do_reset();

      // Forwarding table
      for (int i = 0; i < 7; i++) begin
         ex_src = tbl[i].src; ex_use = tbl[i].use_v;
         prod_rd = tbl[i].rd; prod_wr = tbl[i].wr;
         #1;
         chk($sformatf("fwd_tbl%0d", i), 32'(fwd_sel1), 32'(tbl[i].exp));
         chk($sformatf("fwd_tbl%0d_l3", i), 32'(fwd_sel3), 32'(tbl[i].exp));
      end

      // Register 0 behaviour
      ex_src = 6'd0; ex_use = 2'b01; prod_rd = 6'd0; prod_wr = 2'b01;
      #1;
`ifdef ZERO_REG_EN
      chk("zero_reg", 32'(fwd_sel1), 0);
`else
      chk("zero_reg", 32'(fwd_sel1), 1);
`endif
      clr_inputs();

      // Load-use: LOAD_LAT=1 stalls once, LOAD_LAT=3 stalls three cycles
      do_reset();
      ex_is_load = 1; ex_wr = 1; ex_rd = 3'd5; id_src = {3'd5, 3'd0}; id_use = 2'b10;
      @(negedge clk);
      chk("lu_c0_stall1", 32'(stall1), 1);
      chk("lu_c0_bubble1", 32'(bubble1), 1);
      chk("lu_c0_stall3", 32'(stall3), 1);
      tick();
      ex_wr = 0;
      @(negedge clk);
      chk("lu_c1_stall1", 32'(stall1), 0);
      chk("lu_c1_cnt1", 32'(cnt1), 1);
      chk("lu_c1_stall3", 32'(stall3), 1);
      chk("lu_c1_bubble3", 32'(bubble3), 1);
      tick();
      @(negedge clk);
      chk("lu_c2_stall3", 32'(stall3), 1);
      tick();
      @(negedge clk);
      chk("lu_c3_stall3", 32'(stall3), 0);
      chk("lu_c3_cnt3", 32'(cnt3), 3);
      chk("lu_c3_cnt1", 32'(cnt1), 1);

      // Flush in the second stall cycle
      do_reset();
      ex_is_load = 1; ex_wr = 1; ex_rd = 3'd5; id_src = {3'd5, 3'd0}; id_use = 2'b10;
      @(negedge clk);
      chk("fl_c0_stall3", 32'(stall3), 1);
      tick();
      ex_wr = 0; flush = 1;
      @(negedge clk);
      chk("fl_c1_stall3", 32'(stall3), 0);
      chk("fl_c1_bubble3", 32'(bubble3), 0);
      tick();
      flush = 0;
      @(negedge clk);
      chk("fl_c2_stall3", 32'(stall3), 0);
      chk("fl_c2_cnt3", 32'(cnt3), 1);

      // Asynchronous reset in the middle of a stall
      do_reset();
      ex_is_load = 1; ex_wr = 1; ex_rd = 3'd5; id_src = {3'd5, 3'd0}; id_use = 2'b10;
      tick();
      ex_wr = 0;
      ex_src = {3'd0, 3'd3}; ex_use = 2'b01; prod_rd = {3'd0, 3'd3}; prod_wr = 2'b01;
      #1;
      chk("ar_pre_stall3", 32'(stall3), 1);
      chk("ar_pre_fwd", 32'(fwd_sel3), 1);
      #1;
      rst = 0;
      #1;
      chk("ar_stall3", 32'(stall3), 0);
      chk("ar_bubble3", 32'(bubble3), 0);
      chk("ar_fwd3", 32'(fwd_sel3), 0);
      chk("ar_cnt3", 32'(cnt3), 0);
      tick();
      clr_inputs();
      rst = 1;
      @(negedge clk);
      chk("ar_post_stall3", 32'(stall3), 0);
      tick();
      @(negedge clk);
      chk("ar_post2_stall3", 32'(stall3), 0);
      chk("ar_post2_cnt3", 32'(cnt3), 0);
      chk("ar_post2_fwd3", 32'(fwd_sel3), 0);

      // Random stimulus against the reference model
      do_reset();
      rem1 = 0; rem3 = 0; mc1 = 0; mc3 = 0;
      for (int c = 0; c < 400; c++) begin
         logic [3:0] ef;
         bit h, es1, es3;
         ex_src = 6'($urandom); ex_use = 2'($urandom);
         prod_rd = 6'($urandom); prod_wr = 2'($urandom);
         id_src = 6'($urandom); id_use = 2'($urandom);
         ex_rd = ($urandom_range(0, 1) == 1) ? id_src[2:0] : 3'($urandom);
         ex_wr = 1'($urandom); ex_is_load = 1'($urandom);
         flush = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         ef = m_fwd(ex_src, ex_use, prod_rd, prod_wr);
         h = m_hz(id_src, id_use, ex_rd, ex_wr, ex_is_load);
         es1 = !flush && (rem1 > 0 || h);
         es3 = !flush && (rem3 > 0 || h);
         chk("rnd_fwd1", 32'(fwd_sel1), 32'(ef));
         chk("rnd_fwd3", 32'(fwd_sel3), 32'(ef));
         chk("rnd_stall1", 32'(stall1), 32'(es1));
         chk("rnd_stall3", 32'(stall3), 32'(es3));
         chk("rnd_bubble3", 32'(bubble3), 32'(es3));
         chk("rnd_cnt1", 32'(cnt1), 32'(mc1));
         chk("rnd_cnt3", 32'(cnt3), 32'(mc3));
         rem1 = flush ? 0 : (rem1 > 0) ? rem1 - 1 : (h ? 0 : 0);
         rem3 = flush ? 0 : (rem3 > 0) ? rem3 - 1 : (h ? 2 : 0);
         if (es1 && mc1 < 65535) mc1++;
         if (es3 && mc3 < 65535) mc3++;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
